// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot-product job of runtime length LEN through a
// single shared signed array multiplier, a registered product stage and an
// accumulator, then returns the sum on a valid/ready port.
//
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   START, LEN            job request (sampled only in IDLE) and vector length
//   A_IN, B_IN, IN_VALID  signed operand pair with valid
//   IN_READY              controller accepts a pair (LOAD only)
//   RESULT, OUT_VALID     signed dot product and its valid
//   OUT_READY             consumer takes RESULT
//   BUSY                  controller is not idle

// Combinational signed array multiplier: shift-add of sign-extended operands,
// truncated to 2*W bits, which is exact for two's complement.
module mac_array_mult #(
  parameter int unsigned W = 6
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic signed [2*W-1:0] prod_c_o
);
  localparam int unsigned PW = 2 * W;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] sum;

  // One partial-product row per multiplier bit.
  always_comb begin
    a_ext = PW'(a_i);
    b_ext = PW'(b_i);
    sum   = '0;
    for (int i = 0; i < int'(PW); i++) begin
      if (b_ext[i]) begin
        sum = sum + (a_ext << i);
      end
    end
  end

  assign prod_c_o = $signed(sum);
endmodule

module mac_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1),
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(MAX_LEN)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [LEN_W-1:0]             LEN,
  input  logic signed [DATA_WIDTH-1:0] A_IN,
  input  logic signed [DATA_WIDTH-1:0] B_IN,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  output logic signed [ACC_WIDTH-1:0]  RESULT,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic                         BUSY
);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                     state_q;
  logic signed [PROD_W-1:0]   prod_q;
  logic                       pv_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic [LEN_W-1:0]           cnt_q;
  logic [LEN_W-1:0]           len_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;

  logic signed [PROD_W-1:0]   mult_c;
  logic                       hs_c;
  logic                       last_c;

  mac_array_mult #(.W(DATA_WIDTH)) u_mult (
    .a_i      (A_IN),
    .b_i      (B_IN),
    .prod_c_o (mult_c)
  );

  assign hs_c   = IN_VALID & in_ready_q;
  // This handshake delivers the final pair of the job.
  assign last_c = (cnt_q + LEN_W'(1)) == len_q;

  // Datapath and controller; outputs are registered alongside the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      prod_q      <= '0;
      pv_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pv_q <= hs_c;
      if (hs_c) begin
        prod_q <= mult_c;
        cnt_q  <= cnt_q + LEN_W'(1);
      end
      if (pv_q) begin
        acc_q <= acc_q + ACC_WIDTH'(prod_q);
      end

      case (state_q)
        S_IDLE: begin
          if (START) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            pv_q   <= 1'b0;
            len_q  <= LEN;
            busy_q <= 1'b1;
            if (LEN == '0) begin
              state_q     <= S_OUT;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (hs_c && last_c) begin
            state_q    <= S_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        // Last product is folded into ACC on this edge.
        S_DRAIN: begin
          state_q     <= S_OUT;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (OUT_READY) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign RESULT    = acc_q;
  assign BUSY      = busy_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a table of directed jobs, a reset-during-LOAD
// sequence and 500 random jobs; expected sums go into a scoreboard queue when
// a job is issued and are compared when the result handshake happens.
module tb_mac_seq_ctrl;
  localparam int unsigned DW = 6;
  localparam int unsigned ML = 8;
  localparam int unsigned LW = $clog2(ML + 1);
  localparam int unsigned AW = 2 * DW + $clog2(ML);

  typedef struct {
    int          len;
    int          a[8];
    int          b[8];
    logic [15:0] ivp;
    int          hold;
    bit          noise;
    longint      expv;
  } job_t;

  logic                 CLK;
  logic                 RST;
  logic                 START;
  logic [LW-1:0]        LEN;
  logic signed [DW-1:0] A_IN;
  logic signed [DW-1:0] B_IN;
  logic                 IN_VALID;
  logic                 IN_READY;
  logic signed [AW-1:0] RESULT;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic                 BUSY;

  int     n_checks;
  int     n_errors;
  int     cyc;
  longint sb[$];
  int     hold_left;
  bit     rand_ready;
  int     ov_rises;
  int     ov_cyc;
  int     ir_total;

  mac_seq_ctrl #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (ML),
    .LEN_W      (LW),
    .ACC_WIDTH  (AW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .LEN       (LEN),
    .A_IN      (A_IN),
    .B_IN      (B_IN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .RESULT    (RESULT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got bound expired/unexpected event, expected normal completion (cycle %0d)",
             nm, cyc);
  endtask

  // Result side: drives OUT_READY, checks stability under backpressure and
  // pops the scoreboard on each handshake.
  task automatic monitor();
    bit     prev_ov;
    longint e;
    prev_ov = 1'b0;
    forever begin
      @(negedge CLK);
      if (IN_READY) ir_total++;
      if (OUT_VALID && !prev_ov) begin
        ov_rises++;
        ov_cyc = cyc;
      end
      prev_ov = OUT_VALID;
      if (OUT_VALID && hold_left > 0) begin
        hold_left--;
        OUT_READY = 1'b0;
        if (sb.size() != 0) check("hold_stable", RESULT, sb[0]);
      end else begin
        OUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) fail("unexpected_result");
        else begin
          e = sb.pop_front();
          check("result", RESULT, e);
        end
      end
    end
  endtask

  function automatic job_t uni(input int len, input int av, input int bv,
                               input logic [15:0] ivp, input int hold,
                               input bit noise, input longint expv);
    job_t j;
    j.len = len;
    for (int i = 0; i < 8; i++) begin
      j.a[i] = av;
      j.b[i] = bv;
    end
    j.ivp   = ivp;
    j.hold  = hold;
    j.noise = noise;
    j.expv  = expv;
    return j;
  endfunction

  task automatic run_job(input job_t j, input bit rnd);
    int idx, k, guard, start_edge, last_hs, rises0, ir0;
    bit iv;
    idx = 0; k = 0; guard = 0; last_hs = 0;
    hold_left = j.hold;
    sb.push_back(j.expv);
    @(negedge CLK);
    START = 1'b1;
    LEN = LW'(j.len);
    start_edge = cyc + 1;
    rises0 = ov_rises;
    ir0 = ir_total;
    @(negedge CLK);
    START = 1'b0;
    LEN = '0;
    while (idx < j.len && k < 400) begin
      iv = rnd ? 1'($urandom_range(0, 1)) : j.ivp[k % 16];
      IN_VALID = iv;
      A_IN = iv ? DW'(j.a[idx]) : DW'($urandom);
      B_IN = iv ? DW'(j.b[idx]) : DW'($urandom);
      START = j.noise & ~iv;
      if (iv && IN_READY) begin
        idx++;
        last_hs = cyc + 1;
      end
      k++;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    START = j.noise;
    if (idx < j.len) fail("feed_timeout");
    while ((BUSY || sb.size() != 0) && guard < 300) begin
      @(negedge CLK);
      guard++;
    end
    START = 1'b0;
    if (guard >= 300) begin
      fail("out_timeout");
      sb.delete();
    end
    if (ov_rises == rises0) fail("no_out_valid");
    else check("ov_latency", ov_cyc, (j.len == 0) ? start_edge : last_hs + 1);
    if (!rnd && j.ivp == 16'hFFFF) check("in_ready_cycles", ir_total - ir0, j.len);
    check("result_hold", RESULT, j.expv);
    if (j.noise) begin
      @(negedge CLK);
      check("start_ignored_busy", BUSY, 0);
    end
  endtask

  initial begin
    job_t tbl[7];
    job_t j;
    n_checks = 0; n_errors = 0;
    hold_left = 0; rand_ready = 1'b0;
    ov_rises = 0; ov_cyc = 0; ir_total = 0;
    RST = 1'b1; START = 1'b0; LEN = '0;
    A_IN = '0; B_IN = '0; IN_VALID = 1'b0; OUT_READY = 1'b0;

    tbl[0] = uni(3, 0, 0, 16'hFFFF, 0, 1'b0, 38);
    tbl[0].a[0] = 3;  tbl[0].a[1] = -5; tbl[0].a[2] = -7;
    tbl[0].b[0] = 4;  tbl[0].b[1] = 6;  tbl[0].b[2] = -8;
    tbl[1] = uni(8, -32, -32, 16'hFFFF, 0, 1'b0, 8192);
    tbl[2] = uni(8, -32, 31, 16'hFFFF, 0, 1'b0, -7936);
    tbl[3] = uni(4, 1, 1, 16'h0059, 5, 1'b1, 4);
    tbl[4] = uni(0, 0, 0, 16'hFFFF, 0, 1'b0, 0);
    tbl[5] = uni(2, 2, -3, 16'hFFFF, 0, 1'b0, -12);
    tbl[6] = uni(1, 5, -7, 16'hFFFF, 0, 1'b0, -35);

    repeat (2) @(negedge CLK);
    check("rst_in_ready", IN_READY, 0);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_result", RESULT, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b0;
    fork
      monitor();
    join_none

    for (int t = 0; t < 7; t++) run_job(tbl[t], 1'b0);

    // Asynchronous reset in the middle of LOAD with a non-zero partial sum.
    @(negedge CLK);
    START = 1'b1;
    LEN = LW'(5);
    @(negedge CLK);
    START = 1'b0;
    IN_VALID = 1'b1;
    A_IN = DW'(3);
    B_IN = DW'(3);
    check("mid_load_ready", IN_READY, 1);
    @(negedge CLK);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("arst_in_ready", IN_READY, 0);
    check("arst_out_valid", OUT_VALID, 0);
    check("arst_result", RESULT, 0);
    check("arst_busy", BUSY, 0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    run_job(uni(2, 4, -5, 16'hFFFF, 0, 1'b0, -40), 1'b0);

    rand_ready = 1'b1;
    for (int n = 0; n < 500; n++) begin
      j.len = int'($urandom_range(0, 8));
      j.expv = 0;
      for (int i = 0; i < 8; i++) begin
        j.a[i] = int'($urandom_range(0, 63)) - 32;
        j.b[i] = int'($urandom_range(0, 63)) - 32;
        if (i < j.len) j.expv += longint'(j.a[i] * j.b[i]);
      end
      j.ivp = 16'hFFFF;
      j.hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      j.noise = 1'($urandom_range(0, 1));
      run_job(j, 1'b1);
    end
    rand_ready = 1'b0;

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
